// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: UART-style receive frame controller.
// Tracks the oversample index inside each bit, consumes the sampler's
// majority-voted bit once per bit period, assembles an LSB-first payload and
// reports good frames, parity errors and stop-bit errors as one-cycle strobes.
// Optional parity support is built only when the macro RX_PARITY_EN is defined;
// without it PAR_EN/PAR_TYP are ignored and par_err stays low.
module rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  sampled_bit,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [4:0]            edge_cnt,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Last oversample index for a prescale value; unsupported ratios fall back to 8.
    function automatic logic [4:0] last_edge(input logic [5:0] ps);
        logic [4:0] res;
        case (ps)
            6'd16:   res = 5'd15;
            6'd32:   res = 5'd31;
            default: res = 5'd7;
        endcase
        return res;
    endfunction

    // Expected parity bit: XOR of the payload, inverted for odd parity.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [4:0]            edge_r;
    logic [4:0]            edge_nxt_s;
    logic [4:0]            last_r;
    logic                  consume_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  armed_r;
    logic                  dat_samp_en_r;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  dv_r;
    logic                  pe_r;
    logic                  se_r;
    logic                  start_s;
    logic                  stop_done_s;
    logic                  par_use_s;
    logic                  par_bad_s;

    assign start_s     = (state_r == IDLE) && (state_nxt_s == START);
    assign stop_done_s = (state_r == STOP) && consume_r;

    // Next-state logic; transitions out of a bit state only on its consume cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (armed_r && !RX_IN) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (consume_r) begin
                    if (sampled_bit) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (consume_r && (bit_cnt_r == LAST_BIT)) begin
                    if (par_use_s) begin
                        state_nxt_s = PARITY;
                    end else begin
                        state_nxt_s = STOP;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (consume_r) begin
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                if (consume_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Oversample index: parked at 0 in IDLE and on the first START cycle, wraps at the latched ratio.
    always_comb begin
        edge_nxt_s = edge_r;
        if ((state_nxt_s == IDLE) || (state_r == IDLE)) begin
            edge_nxt_s = 5'd0;
        end else if (edge_r == last_r) begin
            edge_nxt_s = 5'd0;
        end else begin
            edge_nxt_s = edge_r + 5'd1;
        end
    end

    // State register, oversample counter, consume flag and sampler enable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r       <= IDLE;
            edge_r        <= 5'd0;
            consume_r     <= 1'b0;
            dat_samp_en_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            edge_r        <= edge_nxt_s;
            consume_r     <= (state_r != IDLE) && (edge_r == last_r);
            dat_samp_en_r <= (state_nxt_s != IDLE);
        end
    end

    // Bit period is frozen at frame start so mid-frame Prescale changes wait for the next frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_r <= 5'd7;
        end else if (start_s) begin
            last_r <= last_edge(Prescale);
        end else begin
            last_r <= last_r;
        end
    end

    // Payload assembly: each consumed data bit lands at the index given by the bit counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt_r <= '0;
            shift_r   <= '0;
        end else if (start_s) begin
            bit_cnt_r <= '0;
            shift_r   <= shift_r;
        end else if ((state_r == DATA) && consume_r) begin
            bit_cnt_r          <= bit_cnt_r + CNT_W'(1);
            shift_r[bit_cnt_r] <= sampled_bit;
        end else begin
            bit_cnt_r <= bit_cnt_r;
            shift_r   <= shift_r;
        end
    end

    // Break handling: a bad stop bit disarms start detection until the line is seen high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            armed_r <= 1'b1;
        end else if (stop_done_s && !sampled_bit) begin
            armed_r <= 1'b0;
        end else if (RX_IN) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Frame result: strobes for one cycle, payload only updated by a clean frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p_data_r <= '0;
            dv_r     <= 1'b0;
            pe_r     <= 1'b0;
            se_r     <= 1'b0;
        end else if (stop_done_s) begin
            se_r <= !sampled_bit;
            pe_r <= par_bad_s;
            if (sampled_bit && !par_bad_s) begin
                dv_r     <= 1'b1;
                p_data_r <= shift_r;
            end else begin
                dv_r     <= 1'b0;
                p_data_r <= p_data_r;
            end
        end else begin
            p_data_r <= p_data_r;
            dv_r     <= 1'b0;
            pe_r     <= 1'b0;
            se_r     <= 1'b0;
        end
    end

`ifdef RX_PARITY_EN
    logic par_en_r;
    logic par_typ_r;
    logic par_bad_r;

    // Parity configuration captured at frame start; mismatch recorded at the parity consume cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            par_bad_r <= 1'b0;
        end else if (start_s) begin
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
            par_bad_r <= 1'b0;
        end else if ((state_r == PARITY) && consume_r) begin
            par_en_r  <= par_en_r;
            par_typ_r <= par_typ_r;
            par_bad_r <= (sampled_bit != parity_bit(shift_r, par_typ_r));
        end else begin
            par_en_r  <= par_en_r;
            par_typ_r <= par_typ_r;
            par_bad_r <= par_bad_r;
        end
    end

    assign par_use_s = par_en_r;
    assign par_bad_s = par_bad_r;
`else
    logic unused_par_s;

    assign unused_par_s = PAR_EN ^ PAR_TYP;
    assign par_use_s    = 1'b0;
    assign par_bad_s    = 1'b0;
`endif

    assign edge_cnt    = edge_r;
    assign dat_samp_en = dat_samp_en_r;
    assign P_DATA      = p_data_r;
    assign data_valid  = dv_r;
    assign par_err     = pe_r;
    assign stp_err     = se_r;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: self-checking bench for rx_frame_ctrl.
// A bench-side sampler latches RX_IN at oversample index 2 of every bit and
// presents it as sampled_bit. Expected frame results go into a scoreboard
// queue when a frame is driven and are popped when the DUT strobes.
module tb_rx_frame_ctrl;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          sampled_bit;
    logic [5:0]    Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [4:0]    edge_cnt;
    logic          dat_samp_en;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [5:0] ps;
        int         line_ps;
        logic       par_en;
        logic       par_typ;
        logic [7:0] data;
        logic       par_bit;
        logic       stop;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pdata;
    } vec_t;

    exp_t sb_q[$];

    logic samp_hold = 1'b1;
    logic track_en  = 1'b0;
    int   edge_max  = 0;

    rx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .sampled_bit (sampled_bit),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .edge_cnt    (edge_cnt),
        .dat_samp_en (dat_samp_en),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 CLK = ~CLK;

    // Simple sampler stand-in: capture the line early in each bit, hold it through the consume cycle.
    always @(posedge CLK) begin
        if (dat_samp_en && (edge_cnt == 5'd2)) samp_hold <= RX_IN;
    end
    assign sampled_bit = samp_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: each strobe event must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && (data_valid || par_err || stp_err)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 32'({data_valid, par_err, stp_err}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("strobes_dv_pe_se", 32'({data_valid, par_err, stp_err}), 32'({e.dv, e.pe, e.se}));
                if (e.dv) check("pdata_on_valid", 32'(P_DATA), 32'(e.data));
            end
        end
    end

    // Largest oversample index seen while tracking is enabled.
    always begin
        @(posedge CLK);
        #1;
        if (track_en && (int'(edge_cnt) > edge_max)) edge_max = int'(edge_cnt);
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_bit(input logic b, input int ps);
        RX_IN = b;
        repeat (ps) @(negedge CLK);
    endtask

    task automatic send_frame(input int ps, input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop);
        send_bit(1'b0, ps);
        for (int i = 0; i < 8; i++) send_bit(d[i], ps);
        if (par_en) send_bit(par_bit, ps);
        send_bit(stop, ps);
    endtask

    task automatic push_exp(input logic dv, input logic pe, input logic se, input logic [7:0] d);
        exp_t e;
        e.dv   = dv;
        e.pe   = pe;
        e.se   = se;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Idle the line until every expected strobe has been seen (bounded).
    task automatic drain(input string name);
        int k;
        k = 0;
        RX_IN = 1'b1;
        while ((sb_q.size() != 0) && (k < 200)) begin
            @(negedge CLK);
            k++;
        end
        repeat (4) @(negedge CLK);
        check(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        vec_t       vt[7];
        logic [7:0] d1;
        logic [7:0] d2;
        logic       busy;

        RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("rst_samp_en", 32'(dat_samp_en), 32'd0);
        check("rst_pdata", 32'(P_DATA), 32'd0);
        check("rst_strobes", 32'({data_valid, par_err, stp_err}), 32'd0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle_samp_en", 32'(dat_samp_en), 32'd0);

        //           ps     line  pen   ptyp  data   pbit  stop  dv    pe    se    pdata
        vt[0] = '{6'd8,  8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
`ifdef RX_PARITY_EN
        vt[1] = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
`else
        vt[1] = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
`endif
        vt[2] = '{6'd32, 32, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F};
        vt[3] = '{6'd8,  8,  1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
        vt[4] = '{6'd20, 8,  1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96};
        vt[5] = '{6'd16, 16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h96};
`ifdef RX_PARITY_EN
        vt[6] = '{6'd8,  8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h96};
`else
        vt[6] = '{6'd8,  8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h96};
`endif

        for (int i = 0; i < 7; i++) begin
            Prescale = vt[i].ps;
            PAR_EN   = vt[i].par_en;
            PAR_TYP  = vt[i].par_typ;
            push_exp(vt[i].dv, vt[i].pe, vt[i].se, vt[i].data);
            send_frame(vt[i].line_ps, vt[i].data, vt[i].par_en, vt[i].par_bit, vt[i].stop);
            drain("vec_strobe_seen");
            check("vec_pdata", 32'(P_DATA), 32'(vt[i].pdata));
        end
        PAR_EN = 1'b0;

        // Glitch: two-cycle low pulse enters START, samples 1, drops back to IDLE silently.
        Prescale = 6'd8;
        RX_IN = 1'b0;
        @(negedge CLK);
        check("glitch_start_en", 32'(dat_samp_en), 32'd1);
        @(negedge CLK);
        RX_IN = 1'b1;
        repeat (20) @(negedge CLK);
        check("glitch_idle_en", 32'(dat_samp_en), 32'd0);
        check("glitch_pdata", 32'(P_DATA), 32'h96);

        // Break: bad stop bit at Prescale 32, line held low 100 cycles.
        Prescale = 6'd32;
        push_exp(1'b0, 1'b0, 1'b1, 8'hFF);
        send_frame(32, 8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        check("break_stp_seen", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        busy = 1'b0;
        for (int i = 0; i < 96; i++) begin
            @(negedge CLK);
            if (dat_samp_en) busy = 1'b1;
        end
        check("break_no_restart", 32'(busy), 32'd0);
        check("break_pdata", 32'(P_DATA), 32'h96);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        Prescale = 6'd8;
        push_exp(1'b1, 1'b0, 1'b0, 8'h81);
        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1);
        drain("rearm_strobe_seen");
        check("rearm_pdata", 32'(P_DATA), 32'h81);

        // Back-to-back frames; Prescale changes mid first frame and applies to the second.
        Prescale = 6'd16;
        d1 = 8'h12;
        d2 = 8'h34;
        push_exp(1'b1, 1'b0, 1'b0, d1);
        push_exp(1'b1, 1'b0, 1'b0, d2);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) Prescale = 6'd8;
            send_bit(d1[i], 16);
        end
        send_bit(1'b1, 16);
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        edge_max = 0;
        track_en = 1'b1;
        repeat (6) @(negedge CLK);
        for (int i = 0; i < 8; i++) send_bit(d2[i], 8);
        send_bit(1'b1, 8);
        drain("b2b_strobes_seen");
        track_en = 1'b0;
        check("b2b_pdata", 32'(P_DATA), 32'h34);
        check("b2b_edge_max", 32'(edge_max), 32'd7);

        // Reset at data bit 4 aborts the frame; the next frame is received normally.
        Prescale = 6'd8;
        d1 = 8'hC3;
        send_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) send_bit(d1[i], 8);
        RX_IN = d1[4];
        repeat (3) @(negedge CLK);
        check("pre_rst_busy", 32'(dat_samp_en), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("midrst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("midrst_samp_en", 32'(dat_samp_en), 32'd0);
        check("midrst_pdata", 32'(P_DATA), 32'd0);
        check("midrst_strobes", 32'({data_valid, par_err, stp_err}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        RX_IN = 1'b1;
        repeat (20) @(negedge CLK);
        check("post_rst_idle", 32'(dat_samp_en), 32'd0);
        push_exp(1'b1, 1'b0, 1'b0, 8'h5A);
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1);
        drain("post_rst_strobe_seen");
        check("post_rst_pdata", 32'(P_DATA), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 8, number of data bits per frame, LSB first.
REQ-002 SHALL have port: CLK  input  1  oversampling clock; all state on rising edge.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: RX_IN  input  1  serial line, idle high.
REQ-005 SHALL have port: sampled_bit  input  1  majority-voted bit from the sampler, valid the cycle after edge_cnt == Prescale-1.
REQ-006 SHALL have port: Prescale  input  6  oversampling ratio; 8, 16 or 32.
REQ-007 SHALL have port: PAR_EN  input  1  parity bit present in frame.
REQ-008 SHALL have port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port: edge_cnt  output  5  oversample index within current bit.
REQ-010 SHALL have port: dat_samp_en  output  1  sampler enable.
REQ-011 SHALL have port: P_DATA  output  DATA_WIDTH  last good frame payload.
REQ-012 SHALL have port: data_valid  output  1  one-cycle strobe, P_DATA updated.
REQ-013 SHALL have port: par_err  output  1  one-cycle strobe, parity mismatch.
REQ-014 SHALL have port: stp_err  output  1  one-cycle strobe, stop bit sampled 0.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL latch Prescale and PAR_EN/PAR_TYP on the IDLE->START transition; mid-frame changes have no effect until the next frame.
REQ-017 SHALL treat latched Prescale values outside {8,16,32} as 8.
REQ-018 SHALL move IDLE->START when armed and RX_IN == 0; edge_cnt = 0 in that cycle.
REQ-019 SHALL increment edge_cnt each cycle outside IDLE, wrapping Prescale-1 -> 0; a bit-end occurs at each wrap.
REQ-020 SHALL consume sampled_bit in the cycle after each bit-end (the consume cycle).
REQ-021 SHALL assert dat_samp_en in START, DATA, PARITY and STOP; deassert it in IDLE, holding edge_cnt at 0.
REQ-022 SHALL, at the START consume cycle, return to IDLE with no strobes if sampled_bit == 1 (glitch); otherwise enter DATA.
REQ-023 SHALL in DATA shift sampled_bit into bit index 0..DATA_WIDTH-1, LSB first, using a bit counter; after the last bit go to PARITY if PAR_EN, else STOP.
REQ-024 SHALL in PARITY compare sampled_bit against the XOR of the data bits (inverted if PAR_TYP = 1) and register the mismatch.
REQ-025 SHALL at the STOP consume cycle return to IDLE and, in that same cycle, apply exactly one of the following:
 - stop bit 0: pulse stp_err;
 - parity mismatch: pulse par_err;
 - both: pulse both strobes;
 - neither: load P_DATA and pulse data_valid.
REQ-026 SHALL leave P_DATA unchanged on any errored frame.
REQ-027 SHALL, after a stp_err, disarm start detection until RX_IN is seen high for at least one cycle (break handling).
REQ-028 SHALL accept a new start bit on the cycle immediately after STOP completes (back-to-back frames).

Reset
REQ-029 SHALL, on RST, asynchronously force IDLE, armed = 1, edge_cnt = 0, bit counter = 0, dat_samp_en = 0, P_DATA = 0, data_valid = par_err = stp_err = 0.
REQ-030 SHALL abort a frame interrupted by reset mid-operation without any strobe.

Configuration
REQ-031 SHALL gate parity support with macro RX_PARITY_EN:
 - defined: PARITY state and checker are built;
 - undefined: PARITY is never entered, PAR_EN/PAR_TYP are ignored, and par_err is tied 0;
 - ports are identical in both builds.

Verification
REQ-032 SHALL cover: Prescale = 8, PAR_EN = 0, frame 0xA5 with stop = 1 -> data_valid pulse, P_DATA = 0xA5, no error strobes.
REQ-033 SHALL cover: Prescale = 16, PAR_EN = 1, PAR_TYP = 0, 0x3C with parity bit 1 -> par_err pulse, data_valid low, P_DATA unchanged.
REQ-034 SHALL cover: Prescale = 32, 0xFF with stop = 0 and RX_IN held low 100 cycles -> stp_err pulse, no new START until RX_IN goes high.
REQ-035 SHALL cover: RX_IN low pulse lasting 2 cycles at Prescale = 8 -> START entered, sampled_bit = 1, return to IDLE, no strobes.
REQ-036 SHALL cover: frames 0x12 and 0x34 back-to-back at Prescale = 16, with Prescale switched to 8 mid-frame -> both data_valid pulses, and the second frame uses 8.
REQ-037 SHALL cover: RST asserted at data bit 4 -> all outputs return to reset values and the following 0x5A frame is received correctly.
